// File: rtl/ysyx_22050058_lsu_pkg.sv
// Shared encodings for the ysyx_22050058 memory stage: ALU op codes, LSU FSM states,
// access sizes, and a decoder that classifies an ALU op as a memory access.
package ysyx_22050058_lsu_pkg;

    localparam int ALUOP_W = 8;

    localparam logic [ALUOP_W-1:0] EXE_NOP = 8'h00;
    localparam logic [ALUOP_W-1:0] EXE_ADD = 8'h01;
    localparam logic [ALUOP_W-1:0] EXE_SUB = 8'h02;
    localparam logic [ALUOP_W-1:0] EXE_AND = 8'h03;
    localparam logic [ALUOP_W-1:0] EXE_OR  = 8'h04;
    localparam logic [ALUOP_W-1:0] EXE_XOR = 8'h05;
    localparam logic [ALUOP_W-1:0] EXE_SLL = 8'h06;
    localparam logic [ALUOP_W-1:0] EXE_LB  = 8'h20;
    localparam logic [ALUOP_W-1:0] EXE_LH  = 8'h21;
    localparam logic [ALUOP_W-1:0] EXE_LW  = 8'h22;
    localparam logic [ALUOP_W-1:0] EXE_LD  = 8'h23;
    localparam logic [ALUOP_W-1:0] EXE_LBU = 8'h24;
    localparam logic [ALUOP_W-1:0] EXE_LHU = 8'h25;
    localparam logic [ALUOP_W-1:0] EXE_LWU = 8'h26;
    localparam logic [ALUOP_W-1:0] EXE_SB  = 8'h28;
    localparam logic [ALUOP_W-1:0] EXE_SH  = 8'h29;
    localparam logic [ALUOP_W-1:0] EXE_SW  = 8'h2A;
    localparam logic [ALUOP_W-1:0] EXE_SD  = 8'h2B;

    typedef enum logic [1:0] {
        LSU_IDLE     = 2'd0,
        LSU_WAIT_GNT = 2'd1,
        LSU_WAIT_RSP = 2'd2,
        LSU_DONE     = 2'd3
    } lsu_state_e;

    // Encoded as log2 of the access width in bytes.
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } acc_size_e;

    typedef struct packed {
        logic      is_mem;
        logic      is_load;
        logic      is_unsigned;
        acc_size_e size;
    } mem_op_t;

    function automatic mem_op_t decode_mem_op(input logic [ALUOP_W-1:0] op);
        mem_op_t d;
        d = '{is_mem: 1'b0, is_load: 1'b0, is_unsigned: 1'b0, size: SIZE_B};
        case (op)
            EXE_LB:  d = '{is_mem: 1'b1, is_load: 1'b1, is_unsigned: 1'b0, size: SIZE_B};
            EXE_LH:  d = '{is_mem: 1'b1, is_load: 1'b1, is_unsigned: 1'b0, size: SIZE_H};
            EXE_LW:  d = '{is_mem: 1'b1, is_load: 1'b1, is_unsigned: 1'b0, size: SIZE_W};
            EXE_LD:  d = '{is_mem: 1'b1, is_load: 1'b1, is_unsigned: 1'b0, size: SIZE_D};
            EXE_LBU: d = '{is_mem: 1'b1, is_load: 1'b1, is_unsigned: 1'b1, size: SIZE_B};
            EXE_LHU: d = '{is_mem: 1'b1, is_load: 1'b1, is_unsigned: 1'b1, size: SIZE_H};
            EXE_LWU: d = '{is_mem: 1'b1, is_load: 1'b1, is_unsigned: 1'b1, size: SIZE_W};
            EXE_SB:  d = '{is_mem: 1'b1, is_load: 1'b0, is_unsigned: 1'b0, size: SIZE_B};
            EXE_SH:  d = '{is_mem: 1'b1, is_load: 1'b0, is_unsigned: 1'b0, size: SIZE_H};
            EXE_SW:  d = '{is_mem: 1'b1, is_load: 1'b0, is_unsigned: 1'b0, size: SIZE_W};
            EXE_SD:  d = '{is_mem: 1'b1, is_load: 1'b0, is_unsigned: 1'b0, size: SIZE_D};
            default: d = '{is_mem: 1'b0, is_load: 1'b0, is_unsigned: 1'b0, size: SIZE_B};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ysyx_22050058_lsu_align.sv
// Combinational lane logic for the LSU: misalignment check, store strobe/data
// shift into the doubleword, and load field extraction with sign/zero extension.
module ysyx_22050058_lsu_align
    import ysyx_22050058_lsu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [2:0]         off,
    input  logic [DATA_W-1:0]  store_data,
    input  logic [DATA_W-1:0]  rdata,
    output logic               misalign,
    output logic [7:0]         wmask,
    output logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  load_data
);

    mem_op_t           op;
    logic [5:0]        shamt;
    logic [3:0]        lane_end;
    logic [DATA_W-1:0] field;

    assign op       = decode_mem_op(aluop);
    assign shamt    = {off, 3'b000};
    assign lane_end = {1'b0, off} + (4'd1 << op.size);

    // A byte lane is strobed when it falls inside [off, off + access bytes).
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign wmask[gi] = (4'(gi) >= {1'b0, off}) && (4'(gi) < lane_end);
        end
    endgenerate

    assign wdata = store_data << shamt;
    assign field = rdata >> shamt;

    always_comb begin
        misalign = 1'b0;
        case (op.size)
            SIZE_H:  misalign = off[0];
            SIZE_W:  misalign = |off[1:0];
            SIZE_D:  misalign = |off;
            default: misalign = 1'b0;
        endcase
        misalign = misalign & op.is_mem;
    end

    always_comb begin
        load_data = field;
        case (op.size)
            SIZE_B: load_data = op.is_unsigned ? {{(DATA_W-8){1'b0}}, field[7:0]}
                                               : {{(DATA_W-8){field[7]}}, field[7:0]};
            SIZE_H: load_data = op.is_unsigned ? {{(DATA_W-16){1'b0}}, field[15:0]}
                                               : {{(DATA_W-16){field[15]}}, field[15:0]};
            SIZE_W: load_data = op.is_unsigned ? {{(DATA_W-32){1'b0}}, field[31:0]}
                                               : {{(DATA_W-32){field[31]}}, field[31:0]};
            default: load_data = field;
        endcase
    end

endmodule

// File: rtl/ysyx_22050058_lsu.sv
// Memory-access stage: issues aligned loads/stores over a req/gnt/rvalid handshake,
// stalls the pipeline until the access completes, and passes other ops straight to WB.
module ysyx_22050058_lsu
    import ysyx_22050058_lsu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int REGA_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  mem_pc_i,
    input  logic               mem_instvalid_i,
    input  logic [ALUOP_W-1:0] mem_aluop_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    input  logic [ADDR_W-1:0]  mem_addr_i,
    input  logic [REGA_W-1:0]  mem_reg_waddr_i,
    input  logic               mem_we_i,
    input  logic [5:0]         stall,
    output logic               mem_stall_memreq_o,
    output logic               mem_misalign_o,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    output logic [ADDR_W-1:0]  dmem_addr_o,
    output logic [DATA_W-1:0]  dmem_wdata_o,
    output logic [7:0]         dmem_wmask_o,
    input  logic               dmem_gnt_i,
    input  logic               dmem_rvalid_i,
    input  logic [DATA_W-1:0]  dmem_rdata_i,
    output logic [ADDR_W-1:0]  mem_pc_o,
    output logic               mem_instvalid_o,
    output logic [REGA_W-1:0]  mem_reg_waddr_o,
    output logic               mem_we_o,
    output logic [DATA_W-1:0]  mem_wdata_o
);

    lsu_state_e        state_reg, state_next;
    logic [DATA_W-1:0] result_reg, result_next;
    logic [ADDR_W-1:0] pc_reg;
    logic              instvalid_reg;
    logic [REGA_W-1:0] waddr_reg;
    logic              we_reg;
    logic              is_load_reg;
    logic              capture;

    mem_op_t           op;
    logic [ADDR_W-1:0] eff_addr;
    logic              misalign;
    logic [DATA_W-1:0] load_data;
    logic              stall_unused;

    assign stall_unused = ^{stall[5], stall[3:0]};

    // Loads carry their effective address on the wdata path; stores use mem_addr_i.
    assign op       = decode_mem_op(mem_aluop_i);
    assign eff_addr = op.is_load ? ADDR_W'(mem_wdata_i) : mem_addr_i;

    ysyx_22050058_lsu_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .aluop      (mem_aluop_i),
        .off        (eff_addr[2:0]),
        .store_data (mem_wdata_i),
        .rdata      (dmem_rdata_i),
        .misalign   (misalign),
        .wmask      (dmem_wmask_o),
        .wdata      (dmem_wdata_o),
        .load_data  (load_data)
    );

    assign dmem_addr_o = {eff_addr[ADDR_W-1:3], 3'b000};
    assign dmem_we_o   = op.is_mem & ~op.is_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= LSU_IDLE;
            result_reg    <= '0;
            pc_reg        <= '0;
            instvalid_reg <= 1'b0;
            waddr_reg     <= '0;
            we_reg        <= 1'b0;
            is_load_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            if (capture) begin
                pc_reg        <= mem_pc_i;
                instvalid_reg <= mem_instvalid_i;
                waddr_reg     <= mem_reg_waddr_i;
                we_reg        <= mem_we_i;
                is_load_reg   <= op.is_load;
            end
        end
    end

    always_comb begin
        state_next         = state_reg;
        result_next        = result_reg;
        capture            = 1'b0;
        dmem_req_o         = 1'b0;
        mem_stall_memreq_o = 1'b0;
        mem_misalign_o     = 1'b0;
        mem_pc_o           = mem_pc_i;
        mem_instvalid_o    = mem_instvalid_i;
        mem_reg_waddr_o    = mem_reg_waddr_i;
        mem_we_o           = mem_we_i;
        mem_wdata_o        = mem_wdata_i;

        case (state_reg)
            LSU_IDLE: begin
                if (op.is_mem) begin
                    mem_we_o        = 1'b0;
                    mem_wdata_o     = '0;
                    mem_reg_waddr_o = op.is_load ? mem_reg_waddr_i : '0;
                    if (misalign) begin
                        mem_misalign_o = 1'b1;
                    end else begin
                        dmem_req_o         = 1'b1;
                        mem_stall_memreq_o = 1'b1;
                        capture            = 1'b1;
                        if (dmem_gnt_i) begin
                            state_next = op.is_load ? LSU_WAIT_RSP : LSU_DONE;
                        end else begin
                            state_next = LSU_WAIT_GNT;
                        end
                    end
                end
            end
            LSU_WAIT_GNT: begin
                // Address/data/strobes stay stable because upstream is frozen by our stall.
                mem_we_o           = 1'b0;
                mem_wdata_o        = '0;
                mem_reg_waddr_o    = is_load_reg ? waddr_reg : '0;
                dmem_req_o         = 1'b1;
                mem_stall_memreq_o = 1'b1;
                if (dmem_gnt_i) begin
                    state_next = is_load_reg ? LSU_WAIT_RSP : LSU_DONE;
                end
            end
            LSU_WAIT_RSP: begin
                mem_we_o           = 1'b0;
                mem_wdata_o        = '0;
                mem_reg_waddr_o    = waddr_reg;
                mem_stall_memreq_o = 1'b1;
                if (dmem_rvalid_i) begin
                    result_next = load_data;
                    state_next  = LSU_DONE;
                end
            end
            LSU_DONE: begin
                mem_pc_o        = pc_reg;
                mem_instvalid_o = instvalid_reg;
                mem_reg_waddr_o = is_load_reg ? waddr_reg : '0;
                mem_we_o        = is_load_reg & we_reg;
                mem_wdata_o     = is_load_reg ? result_reg : '0;
                if (!stall[4]) begin
                    state_next = LSU_IDLE;
                end
            end
            default: state_next = LSU_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22050058_lsu.sv
// Directed bench for the LSU: write-back results are queued when an op is driven
// and popped when the stage presents them, alongside per-cycle handshake checks.
module tb_ysyx_22050058_lsu;
    import ysyx_22050058_lsu_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [63:0]        mem_pc_i;
    logic               mem_instvalid_i;
    logic [ALUOP_W-1:0] mem_aluop_i;
    logic [63:0]        mem_wdata_i;
    logic [63:0]        mem_addr_i;
    logic [4:0]         mem_reg_waddr_i;
    logic               mem_we_i;
    logic [5:0]         stall;
    logic               mem_stall_memreq_o;
    logic               mem_misalign_o;
    logic               dmem_req_o;
    logic               dmem_we_o;
    logic [63:0]        dmem_addr_o;
    logic [63:0]        dmem_wdata_o;
    logic [7:0]         dmem_wmask_o;
    logic               dmem_gnt_i;
    logic               dmem_rvalid_i;
    logic [63:0]        dmem_rdata_i;
    logic [63:0]        mem_pc_o;
    logic               mem_instvalid_o;
    logic [4:0]         mem_reg_waddr_o;
    logic               mem_we_o;
    logic [63:0]        mem_wdata_o;

    always #5 clk = ~clk;

    ysyx_22050058_lsu dut (
        .clk                (clk),
        .rst                (rst),
        .mem_pc_i           (mem_pc_i),
        .mem_instvalid_i    (mem_instvalid_i),
        .mem_aluop_i        (mem_aluop_i),
        .mem_wdata_i        (mem_wdata_i),
        .mem_addr_i         (mem_addr_i),
        .mem_reg_waddr_i    (mem_reg_waddr_i),
        .mem_we_i           (mem_we_i),
        .stall              (stall),
        .mem_stall_memreq_o (mem_stall_memreq_o),
        .mem_misalign_o     (mem_misalign_o),
        .dmem_req_o         (dmem_req_o),
        .dmem_we_o          (dmem_we_o),
        .dmem_addr_o        (dmem_addr_o),
        .dmem_wdata_o       (dmem_wdata_o),
        .dmem_wmask_o       (dmem_wmask_o),
        .dmem_gnt_i         (dmem_gnt_i),
        .dmem_rvalid_i      (dmem_rvalid_i),
        .dmem_rdata_i       (dmem_rdata_i),
        .mem_pc_o           (mem_pc_o),
        .mem_instvalid_o    (mem_instvalid_o),
        .mem_reg_waddr_o    (mem_reg_waddr_o),
        .mem_we_o           (mem_we_o),
        .mem_wdata_o        (mem_wdata_o)
    );

    typedef struct {
        logic [63:0] wdata;
        logic [4:0]  waddr;
        logic        we;
    } wb_t;

    wb_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  stall_cnt;
    int  req_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mem_pc_i        = '0;
        mem_instvalid_i = 1'b0;
        mem_aluop_i     = EXE_NOP;
        mem_wdata_i     = '0;
        mem_addr_i      = '0;
        mem_reg_waddr_i = '0;
        mem_we_i        = 1'b0;
        dmem_gnt_i      = 1'b0;
        dmem_rvalid_i   = 1'b0;
        dmem_rdata_i    = '0;
    endtask

    task automatic push_wb(input logic [63:0] d, input logic [4:0] a, input logic w);
        wb_t e;
        e.wdata = d;
        e.waddr = a;
        e.we    = w;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        wb_t e;
        check({tag, "_avail"}, 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_wdata"}, mem_wdata_o, e.wdata);
            check({tag, "_waddr"}, 64'(mem_reg_waddr_o), 64'(e.waddr));
            check({tag, "_we"}, 64'(mem_we_o), 64'(e.we));
        end
    endtask

    initial begin
        rst   = 1'b1;
        stall = '0;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        sample();
        check("rst_req", 64'(dmem_req_o), 64'd0);
        check("rst_stall", 64'(mem_stall_memreq_o), 64'd0);
        check("rst_misalign", 64'(mem_misalign_o), 64'd0);
        check("rst_we", 64'(mem_we_o), 64'd0);
        check("rst_wdata", mem_wdata_o, 64'd0);
        check("rst_state", 64'(dut.state_reg), 64'(LSU_IDLE));
        check("rst_result", dut.result_reg, 64'd0);
        $display("txn reset");

        // ADD pass-through
        step();
        mem_aluop_i = EXE_ADD; mem_wdata_i = 64'h1234; mem_we_i = 1'b1;
        mem_reg_waddr_i = 5'd5; mem_pc_i = 64'h8000_0100; mem_instvalid_i = 1'b1;
        push_wb(64'h1234, 5'd5, 1'b1);
        sample();
        check("add_req", 64'(dmem_req_o), 64'd0);
        check("add_stall", 64'(mem_stall_memreq_o), 64'd0);
        check("add_pc", mem_pc_o, 64'h8000_0100);
        pop_check("add");
        $display("txn ADD pass-through wdata=%h", mem_wdata_o);

        // LB, immediate grant, rvalid next cycle
        step();
        mem_aluop_i = EXE_LB; mem_wdata_i = 64'h8000_0003; mem_we_i = 1'b1;
        mem_reg_waddr_i = 5'd7; mem_pc_i = 64'h8000_0104; dmem_gnt_i = 1'b1;
        push_wb(64'hFFFF_FFFF_FFFF_FF80, 5'd7, 1'b1);
        stall_cnt = 0;
        sample();
        stall_cnt += int'(mem_stall_memreq_o);
        check("lb_req", 64'(dmem_req_o), 64'd1);
        check("lb_addr", dmem_addr_o, 64'h8000_0000);
        check("lb_dmem_we", 64'(dmem_we_o), 64'd0);
        check("lb_we_early", 64'(mem_we_o), 64'd0);
        step();
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h0000_0000_80FF_0000;
        sample();
        stall_cnt += int'(mem_stall_memreq_o);
        check("lb_req_rsp", 64'(dmem_req_o), 64'd0);
        step();
        dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        sample();
        stall_cnt += int'(mem_stall_memreq_o);
        pop_check("lb");
        check("lb_stall_cycles", 64'(stall_cnt), 64'd2);
        $display("txn LB wdata=%h stall_cycles=%0d", mem_wdata_o, stall_cnt);
        step();
        idle_inputs();

        // SH with grant withheld for three cycles
        step();
        mem_aluop_i = EXE_SH; mem_addr_i = 64'h8000_0006; mem_wdata_i = 64'hABCD;
        mem_we_i = 1'b0; mem_reg_waddr_i = 5'd9; dmem_gnt_i = 1'b0;
        push_wb(64'd0, 5'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                step();
                dmem_gnt_i = (c == 3);
            end
            sample();
            check("sh_req", 64'(dmem_req_o), 64'd1);
            check("sh_wmask", 64'(dmem_wmask_o), 64'hC0);
            check("sh_wdata", dmem_wdata_o, 64'hABCD_0000_0000_0000);
            check("sh_addr", dmem_addr_o, 64'h8000_0000);
            check("sh_dmem_we", 64'(dmem_we_o), 64'd1);
            check("sh_stall", 64'(mem_stall_memreq_o), 64'd1);
        end
        step();
        dmem_gnt_i = 1'b0;
        sample();
        check("sh_done_state", 64'(dut.state_reg), 64'(LSU_DONE));
        check("sh_done_req", 64'(dmem_req_o), 64'd0);
        check("sh_done_stall", 64'(mem_stall_memreq_o), 64'd0);
        pop_check("sh");
        $display("txn SH wmask=%h", dmem_wmask_o);
        step();
        idle_inputs();

        // Misaligned LW
        step();
        mem_aluop_i = EXE_LW; mem_wdata_i = 64'h8000_0002; mem_we_i = 1'b1; mem_reg_waddr_i = 5'd2;
        sample();
        check("lw_mis_pulse", 64'(mem_misalign_o), 64'd1);
        check("lw_mis_req", 64'(dmem_req_o), 64'd0);
        check("lw_mis_stall", 64'(mem_stall_memreq_o), 64'd0);
        check("lw_mis_we", 64'(mem_we_o), 64'd0);
        step();
        idle_inputs();
        sample();
        check("lw_mis_end", 64'(mem_misalign_o), 64'd0);
        check("lw_mis_req2", 64'(dmem_req_o), 64'd0);
        $display("txn LW misaligned");

        // LWU with stall[4] held for four cycles in DONE
        step();
        mem_aluop_i = EXE_LWU; mem_wdata_i = 64'h8000_0004; mem_we_i = 1'b1;
        mem_reg_waddr_i = 5'd3; dmem_gnt_i = 1'b1;
        push_wb(64'h0000_0000_FFFF_FFFF, 5'd3, 1'b1);
        req_cnt = 0;
        sample();
        req_cnt += int'(dmem_req_o);
        check("lwu_addr", dmem_addr_o, 64'h8000_0000);
        step();
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hFFFF_FFFF_8000_0000;
        stall = 6'b010000;
        sample();
        req_cnt += int'(dmem_req_o);
        step();
        dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) step();
            sample();
            req_cnt += int'(dmem_req_o);
            if (c == 0) begin
                pop_check("lwu");
            end else begin
                check("lwu_hold_wdata", mem_wdata_o, 64'h0000_0000_FFFF_FFFF);
                check("lwu_hold_we", 64'(mem_we_o), 64'd1);
            end
            check("lwu_hold_stall", 64'(mem_stall_memreq_o), 64'd0);
        end
        step();
        stall = '0;
        sample();
        req_cnt += int'(dmem_req_o);
        check("lwu_single_req", 64'(req_cnt), 64'd1);
        $display("txn LWU wdata=%h reqs=%0d", mem_wdata_o, req_cnt);
        step();
        idle_inputs();

        // Back-to-back SD then SB
        step();
        mem_aluop_i = EXE_SD; mem_addr_i = 64'h8000_0010; mem_wdata_i = 64'h1122_3344_5566_7788;
        dmem_gnt_i = 1'b1;
        push_wb(64'd0, 5'd0, 1'b0);
        sample();
        check("sd_wmask", 64'(dmem_wmask_o), 64'hFF);
        check("sd_wdata", dmem_wdata_o, 64'h1122_3344_5566_7788);
        check("sd_addr", dmem_addr_o, 64'h8000_0010);
        step();
        dmem_gnt_i = 1'b0;
        sample();
        pop_check("sd");
        $display("txn SD");
        step();
        mem_aluop_i = EXE_SB; mem_addr_i = 64'h8000_0015; mem_wdata_i = 64'hAB; dmem_gnt_i = 1'b1;
        push_wb(64'd0, 5'd0, 1'b0);
        sample();
        check("sb_b2b_req", 64'(dmem_req_o), 64'd1);
        check("sb_wmask", 64'(dmem_wmask_o), 64'h20);
        check("sb_wdata", dmem_wdata_o, 64'h0000_AB00_0000_0000);
        check("sb_addr", dmem_addr_o, 64'h8000_0010);
        step();
        dmem_gnt_i = 1'b0;
        sample();
        pop_check("sb");
        $display("txn SB back-to-back");
        step();
        idle_inputs();

        // Reset while waiting for load data; late rvalid must be dropped
        step();
        mem_aluop_i = EXE_LD; mem_wdata_i = 64'h8000_0008; mem_we_i = 1'b1;
        mem_reg_waddr_i = 5'd4; dmem_gnt_i = 1'b1;
        sample();
        check("ld_req", 64'(dmem_req_o), 64'd1);
        step();
        dmem_gnt_i = 1'b0; rst = 1'b1;
        sample();
        check("ld_wait_rsp", 64'(dut.state_reg), 64'(LSU_WAIT_RSP));
        step();
        rst = 1'b0;
        idle_inputs();
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hDEAD_BEEF_0000_1111;
        sample();
        check("rstmid_state", 64'(dut.state_reg), 64'(LSU_IDLE));
        check("rstmid_req", 64'(dmem_req_o), 64'd0);
        check("rstmid_stall", 64'(mem_stall_memreq_o), 64'd0);
        check("rstmid_result", dut.result_reg, 64'd0);
        step();
        dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        sample();
        check("late_rvalid_we", 64'(mem_we_o), 64'd0);
        check("late_rvalid_result", dut.result_reg, 64'd0);
        check("late_rvalid_state", 64'(dut.state_reg), 64'(LSU_IDLE));
        $display("txn reset during WAIT_RSP");

        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
